// File: rtl/switch_debouncer_if.sv
// Switch/button conditioning interface.
// Groups the raw board pins and the conditioned outputs of switch_debouncer.
// There is no valid/ready handshake on this bus: sw_raw/btn_raw are free-running
// asynchronous pins, sw_level/pause are levels, and sw_rise/sw_fall/sw_change/
// btn_press are single-cycle pulses that the consumer must sample every clock.
interface switch_debouncer_if #(
   parameter int WIDTH = 8
) ();
   logic [WIDTH-1:0] sw_raw;
   logic             btn_raw;
   logic [WIDTH-1:0] sw_level;
   logic [WIDTH-1:0] sw_rise;
   logic [WIDTH-1:0] sw_fall;
   logic             sw_change;
   logic             btn_press;
   logic             pause;

   // Board / stimulus side: drives the pins, watches the conditioned outputs.
   modport master (
      output sw_raw, btn_raw,
      input  sw_level, sw_rise, sw_fall, sw_change, btn_press, pause
   );

   // Debouncer side.
   modport slave (
      input  sw_raw, btn_raw,
      output sw_level, sw_rise, sw_fall, sw_change, btn_press, pause
   );
endinterface

// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronizes, debounces and edge-detects the slide switches
// and the pause button in the clk_orig domain.
// Optional feature macro: PAUSE_TOGGLE_EN
//   defined   -> pause is a register toggled by each btn_press
//   undefined -> pause is the debounced button level
module switch_debouncer #(
   parameter int WIDTH     = 8,
   parameter int DB_CYCLES = 1000000,
   parameter int CNT_W     = 20
) (
   input logic            clk,
   input logic            rst_n,
   switch_debouncer_if.slave bus
);

   // Channel WIDTH is the pause button; channels 0..WIDTH-1 are the switches.
   localparam int N = WIDTH + 1;
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

   logic [N-1:0] raw;
   logic [N-1:0] sync_s1;
   logic [N-1:0] sync_s2;
   logic [N-1:0] level;
   logic [N-1:0] accept;

   assign raw = {bus.btn_raw, bus.sw_raw};

   // Two-flop synchronizer for every raw pin; only sync_s2 feeds the debounce.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_s1 <= '0;
         sync_s2 <= '0;
      end else begin
         sync_s1 <= raw;
         sync_s2 <= sync_s1;
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_db
      logic [CNT_W-1:0] cnt_q;
      logic             level_q;
      logic             accept_q;

      // Per-channel debounce: count consecutive cycles that disagree with the
      // accepted level; on the last one adopt the new level and flag acceptance.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q    <= '0;
            level_q  <= 1'b0;
            accept_q <= 1'b0;
         end else begin
            accept_q <= 1'b0;
            if (sync_s2[i] == level_q) begin
               cnt_q <= '0;
            end else if (cnt_q == DB_LAST) begin
               cnt_q    <= '0;
               level_q  <= sync_s2[i];
               accept_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end
      end

      assign level[i]  = level_q;
      assign accept[i] = accept_q;
   end

   // The accept flag and the new level are registered on the same edge, so the
   // direction of the accepted change is simply the current level.
   assign bus.sw_level  = level[WIDTH-1:0];
   assign bus.sw_rise   = accept[WIDTH-1:0] & level[WIDTH-1:0];
   assign bus.sw_fall   = accept[WIDTH-1:0] & ~level[WIDTH-1:0];
   assign bus.sw_change = |accept[WIDTH-1:0];
   assign bus.btn_press = accept[WIDTH] & level[WIDTH];

`ifdef PAUSE_TOGGLE_EN
   logic pause_q;

   // Press = pause, press again = resume; visible the cycle after btn_press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pause_q <= 1'b0;
      end else if (bus.btn_press) begin
         pause_q <= ~pause_q;
      end
   end

   assign bus.pause = pause_q;
`else
   // Pause only while the button is held (debounced level).
   assign bus.pause = level[WIDTH];
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Testbench for switch_debouncer (DB_CYCLES=4, CNT_W=3).
// Pulse events are predicted as {cycle, rise, fall, change, press} words when
// stimulus is driven and matched by a monitor when the DUT pulses.
module tb_switch_debouncer;

   localparam int WIDTH = 8;
   localparam int LAT   = 6;               // 2 sync + 4 debounce cycles
   localparam int W     = 32 + 2*WIDTH + 2;

   logic        clk;
   logic        rst_n;
   logic [31:0] cyc;
   int          n_cmp;
   int          n_fail;
   logic [W-1:0] exp_q[$];

   switch_debouncer_if #(.WIDTH(WIDTH)) bus ();

   switch_debouncer #(
      .WIDTH     (WIDTH),
      .DB_CYCLES (4),
      .CNT_W     (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- clock / reset block ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 32'd1;

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [W-1:0] obs;
      logic [W-1:0] exp_w;
      if ((bus.sw_rise !== '0) || (bus.sw_fall !== '0) ||
          (bus.sw_change !== 1'b0) || (bus.btn_press !== 1'b0)) begin
         obs = {cyc, bus.sw_rise, bus.sw_fall, bus.sw_change, bus.btn_press};
         n_cmp = n_cmp + 1;
         if (exp_q.size() == 0) begin
            n_fail = n_fail + 1;
            $display("FAIL unexpected_pulse: cyc=%0d rise=%h fall=%h chg=%b press=%b, required no pulse",
                     cyc, bus.sw_rise, bus.sw_fall, bus.sw_change, bus.btn_press);
         end else begin
            exp_w = exp_q.pop_front();
            if (obs !== exp_w) begin
               n_fail = n_fail + 1;
               $display("FAIL pulse_event: got cyc=%0d rise=%h fall=%h chg=%b press=%b, required cyc=%0d rise=%h fall=%h chg=%b press=%b",
                        obs[W-1 -: 32], obs[2*WIDTH+1 -: WIDTH], obs[WIDTH+1 -: WIDTH], obs[1], obs[0],
                        exp_w[W-1 -: 32], exp_w[2*WIDTH+1 -: WIDTH], exp_w[WIDTH+1 -: WIDTH], exp_w[1], exp_w[0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic push_event(input logic [31:0] at, input logic [WIDTH-1:0] rise,
                             input logic [WIDTH-1:0] fall, input logic chg, input logic press);
      exp_q.push_back({at, rise, fall, chg, press});
   endtask

   task automatic test_reset;
      rst_n       = 1'b0;
      bus.sw_raw  = '0;
      bus.btn_raw = 1'b0;
      tick(3);
      n_cmp = n_cmp + 1;
      if (bus.sw_level !== 8'h00) begin
         n_fail = n_fail + 1;
         $display("FAIL reset_level: got %h required 00", bus.sw_level);
      end
      n_cmp = n_cmp + 1;
      if ({bus.sw_rise, bus.sw_fall, bus.sw_change, bus.btn_press, bus.pause} !== '0) begin
         n_fail = n_fail + 1;
         $display("FAIL reset_pulses: got rise=%h fall=%h chg=%b press=%b pause=%b required all 0",
                  bus.sw_rise, bus.sw_fall, bus.sw_change, bus.btn_press, bus.pause);
      end
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic test_single_rise;
      logic [31:0] c0;
      logic [WIDTH-1:0] exp_lvl;
      c0 = cyc;
      bus.sw_raw = 8'h08;
      push_event(c0 + LAT, 8'h08, 8'h00, 1'b1, 1'b0);
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         exp_lvl = (k >= LAT) ? 8'h08 : 8'h00;
         n_cmp = n_cmp + 1;
         if (bus.sw_level !== exp_lvl) begin
            n_fail = n_fail + 1;
            $display("FAIL single_rise_level k=%0d: got %h required %h", k, bus.sw_level, exp_lvl);
         end
      end
   endtask

   task automatic test_glitch;
      bus.sw_raw[0] = 1'b1;
      tick(3);
      bus.sw_raw[0] = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         n_cmp = n_cmp + 1;
         if (bus.sw_level !== 8'h08) begin
            n_fail = n_fail + 1;
            $display("FAIL glitch_level k=%0d: got %h required 08", k, bus.sw_level);
         end
      end
   endtask

   task automatic test_multi_bit;
      logic [WIDTH-1:0] exp_lvl;
      bus.sw_raw = 8'h00;
      push_event(cyc + LAT, 8'h00, 8'h08, 1'b1, 1'b0);
      tick(8);
      bus.sw_raw = 8'hA5;
      push_event(cyc + LAT, 8'hA5, 8'h00, 1'b1, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         exp_lvl = (k >= LAT) ? 8'hA5 : 8'h00;
         n_cmp = n_cmp + 1;
         if (bus.sw_level !== exp_lvl) begin
            n_fail = n_fail + 1;
            $display("FAIL multi_rise_level k=%0d: got %h required %h", k, bus.sw_level, exp_lvl);
         end
      end
      bus.sw_raw = 8'h00;
      push_event(cyc + LAT, 8'h00, 8'hA5, 1'b1, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         exp_lvl = (k >= LAT) ? 8'h00 : 8'hA5;
         n_cmp = n_cmp + 1;
         if (bus.sw_level !== exp_lvl) begin
            n_fail = n_fail + 1;
            $display("FAIL multi_fall_level k=%0d: got %h required %h", k, bus.sw_level, exp_lvl);
         end
      end
   endtask

   task automatic test_button;
      logic [31:0] c0;
      logic        exp_p;
      c0 = cyc;
      push_event(c0 + LAT,      8'h00, 8'h00, 1'b0, 1'b1);
      push_event(c0 + 20 + LAT, 8'h00, 8'h00, 1'b0, 1'b1);
      for (int k = 0; k < 40; k++) begin
         bus.btn_raw = ((k < 10) || (k >= 20 && k < 30)) ? 1'b1 : 1'b0;
         @(negedge clk);
`ifdef PAUSE_TOGGLE_EN
         exp_p = ((k + 1) >= 7 && (k + 1) < 27) ? 1'b1 : 1'b0;
`else
         exp_p = (((k + 1) >= 6 && (k + 1) < 16) || ((k + 1) >= 26 && (k + 1) < 36)) ? 1'b1 : 1'b0;
`endif
         n_cmp = n_cmp + 1;
         if (bus.pause !== exp_p) begin
            n_fail = n_fail + 1;
            $display("FAIL button_pause offset=%0d: got %b required %b", k + 1, bus.pause, exp_p);
         end
      end
   endtask

   task automatic test_reset_mid_count;
      logic [31:0] c1;
      logic [WIDTH-1:0] exp_lvl;
      bus.sw_raw = 8'h01;
      push_event(cyc + LAT, 8'h01, 8'h00, 1'b1, 1'b0);
      tick(8);
      bus.sw_raw = 8'h81;
      tick(4);
      rst_n = 1'b0;
      #1;
      n_cmp = n_cmp + 1;
      if (bus.sw_level !== 8'h00) begin
         n_fail = n_fail + 1;
         $display("FAIL midreset_level: got %h required 00", bus.sw_level);
      end
      n_cmp = n_cmp + 1;
      if ({bus.sw_rise, bus.sw_fall, bus.sw_change, bus.btn_press, bus.pause} !== '0) begin
         n_fail = n_fail + 1;
         $display("FAIL midreset_outputs: got rise=%h fall=%h chg=%b press=%b pause=%b required all 0",
                  bus.sw_rise, bus.sw_fall, bus.sw_change, bus.btn_press, bus.pause);
      end
      tick(2);
      rst_n = 1'b1;
      c1 = cyc;
      push_event(c1 + LAT, 8'h81, 8'h00, 1'b1, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         exp_lvl = (k >= LAT) ? 8'h81 : 8'h00;
         n_cmp = n_cmp + 1;
         if (bus.sw_level !== exp_lvl) begin
            n_fail = n_fail + 1;
            $display("FAIL midreset_recount k=%0d: got %h required %h", k, bus.sw_level, exp_lvl);
         end
      end
      bus.sw_raw = 8'h00;
      push_event(cyc + LAT, 8'h00, 8'h81, 1'b1, 1'b0);
      tick(8);
   endtask

   task automatic test_high_at_reset;
      logic [31:0] c1;
      logic [WIDTH-1:0] exp_lvl;
      rst_n      = 1'b0;
      bus.sw_raw = 8'hFF;
      tick(2);
      rst_n = 1'b1;
      c1 = cyc;
      push_event(c1 + LAT, 8'hFF, 8'h00, 1'b1, 1'b0);
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         exp_lvl = (k >= LAT) ? 8'hFF : 8'h00;
         n_cmp = n_cmp + 1;
         if (bus.sw_level !== exp_lvl) begin
            n_fail = n_fail + 1;
            $display("FAIL high_at_reset_level k=%0d: got %h required %h", k, bus.sw_level, exp_lvl);
         end
      end
   endtask

   task automatic check_drained(input string name);
      n_cmp = n_cmp + 1;
      if (exp_q.size() != 0) begin
         n_fail = n_fail + 1;
         $display("FAIL %s_missing_pulses: got %0d pending required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      cyc         = '0;
      n_cmp       = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      bus.sw_raw  = '0;
      bus.btn_raw = 1'b0;

      test_reset;
      test_single_rise;
      check_drained("single_rise");
      test_glitch;
      check_drained("glitch");
      test_multi_bit;
      check_drained("multi_bit");
      test_button;
      check_drained("button");
      test_reset_mid_count;
      check_drained("reset_mid_count");
      test_high_at_reset;
      check_drained("high_at_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
